// File: rtl/lecteur_historique_de_pkg.sv
// Shared constants and helpers for the die-roll history reader.
// - DEPTH_MAX    : largest supported history depth
// - RES_W        : width of a roll result (0..127)
// - BCD_W        : width of one BCD digit
// - IDX_W        : width of the view index output
// - HCNT_W       : width of the entry-count output (holds 0..DEPTH_MAX)
// - BTN_*        : bit positions of the three buttons in the internal vector
// - log2_depth() : pointer width for a power-of-two depth (at least 1)
package lecteur_historique_de_pkg;

  localparam int DEPTH_MAX = 16;
  localparam int RES_W     = 7;
  localparam int BCD_W     = 4;
  localparam int IDX_W     = 4;
  localparam int HCNT_W    = 5;

  localparam int N_BTN      = 3;
  localparam int BTN_LANCER = 0;
  localparam int BTN_PREC   = 1;
  localparam int BTN_SUIV   = 2;

  function automatic int log2_depth(input int depth);
    int w;
    w = 1;
    for (int i = 1; i <= 4; i++) begin
      if ((1 << i) <= depth) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/lecteur_historique_de_anti_rebond.sv
// Button conditioner: 2-FF synchronizer, debouncer and rising-edge pulse.
// Ports:
//   clk     : system clock
//   srst    : synchronous reset, active-high
//   btn_raw : raw asynchronous button level, active-high
//   pulse   : one-cycle pulse when the debounced level rises
module lecteur_historique_de_anti_rebond #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic srst,
  input  logic btn_raw,
  output logic pulse
);

  logic [1:0]       sync_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pulse_reg;

  // The synchronizer keeps running during reset so that the accepted level
  // can be preloaded with the current button state: a button held through
  // reset then has to be released and pressed again before it pulses.
  always_ff @(posedge clk) begin
    sync_reg <= {sync_reg[0], btn_raw};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      level_reg <= sync_reg[1];
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      pulse_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        // Any return to the accepted level restarts the stability count.
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive cycle of the new level.
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
        pulse_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/lecteur_historique_de.sv
// Die-roll history reader: stores each launched roll in a circular buffer and
// lets the player scroll through past rolls, with binary and BCD readout.
// Ports:
//   ClkIn     : system clock
//   RstIn     : synchronous reset, active-high
//   BLancer   : raw launch button (stores Result)
//   BPrec     : raw "older roll" button
//   BSuiv     : raw "newer roll" button
//   Result    : latched roll value, 0..127
//   HistVal   : selected history value (0 when empty)
//   HistIdx   : age of the selected entry, 0 = newest
//   HistCount : number of valid entries, 0..DEPTH
//   HistValid : at least one entry stored
//   Hist_Uni / Hist_Diz / Hist_Ce : BCD units / tens / hundreds of HistVal
module lecteur_historique_de
  import lecteur_historique_de_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic             ClkIn,
  input  logic             RstIn,
  input  logic             BLancer,
  input  logic             BPrec,
  input  logic             BSuiv,
  input  logic [RES_W-1:0] Result,
  output logic [RES_W-1:0] HistVal,
  output logic [IDX_W-1:0] HistIdx,
  output logic [HCNT_W-1:0] HistCount,
  output logic             HistValid,
  output logic [BCD_W-1:0] Hist_Uni,
  output logic [BCD_W-1:0] Hist_Diz,
  output logic [BCD_W-1:0] Hist_Ce
);

  localparam int PTR_W = log2_depth(DEPTH);

  // ---------------------------------------------------------------- buttons
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_pulse;

  assign btn_raw = {BSuiv, BPrec, BLancer};

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      lecteur_historique_de_anti_rebond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_anti_rebond (
        .clk    (ClkIn),
        .srst   (RstIn),
        .btn_raw(btn_raw[gi]),
        .pulse  (btn_pulse[gi])
      );
    end
  endgenerate

  logic launch;
  logic prec;
  logic suiv;

  assign launch = btn_pulse[BTN_LANCER];
  assign prec   = btn_pulse[BTN_PREC];
  assign suiv   = btn_pulse[BTN_SUIV];

  // ------------------------------------------------------------ state
  logic [RES_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [HCNT_W-1:0] count_reg, count_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [RES_W-1:0]  hist_val_reg;
  logic [PTR_W-1:0]  rd_addr;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    idx_next    = idx_reg;
    if (launch) begin
      // Launch wins over any browse pulse arriving in the same cycle.
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (count_reg != HCNT_W'(DEPTH)) count_next = count_reg + HCNT_W'(1);
      idx_next = '0;
    end else if (prec && !suiv) begin
      // Also a no-op while empty, since idx + 1 < 0 never holds.
      if (({1'b0, idx_reg} + HCNT_W'(1)) < count_reg) idx_next = idx_reg + IDX_W'(1);
    end else if (suiv && !prec) begin
      if (idx_reg != '0) idx_next = idx_reg - IDX_W'(1);
    end
  end

  // Read address from the post-update pointers so the readout lands one
  // cycle after the pulse.
  assign rd_addr = wr_ptr_next - PTR_W'(1) - PTR_W'(idx_next);

  always_ff @(posedge ClkIn) begin
    if (launch) mem[wr_ptr_reg] <= Result;
  end

  always_ff @(posedge ClkIn) begin
    if (RstIn) begin
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      idx_reg      <= '0;
      hist_val_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      idx_reg    <= idx_next;
      if (count_next == '0) begin
        hist_val_reg <= '0;
      end else if (launch) begin
        // The entry being written is the one to show; bypass the array so a
        // read-first RAM does not return the stale slot.
        hist_val_reg <= Result;
      end else begin
        hist_val_reg <= mem[rd_addr];
      end
    end
  end

  // ------------------------------------------------------------ BCD split
  logic             ce;
  logic [RES_W-1:0] rem_hund;
  logic [BCD_W-1:0] tens;
  logic [RES_W-1:0] units;

  always_comb begin
    ce       = (hist_val_reg >= RES_W'(100));
    rem_hund = ce ? (hist_val_reg - RES_W'(100)) : hist_val_reg;
    tens     = '0;
    units    = rem_hund;
    // Thresholds are monotonic, so the last one crossed gives the tens digit.
    for (int k = 1; k <= 9; k++) begin
      if (rem_hund >= RES_W'(10 * k)) begin
        tens  = BCD_W'(k);
        units = rem_hund - RES_W'(10 * k);
      end
    end
  end

  assign HistVal   = hist_val_reg;
  assign HistIdx   = idx_reg;
  assign HistCount = count_reg;
  assign HistValid = (count_reg != '0);
  assign Hist_Ce   = {{(BCD_W-1){1'b0}}, ce};
  assign Hist_Diz  = tens;
  assign Hist_Uni  = BCD_W'(units);

endmodule

// File: tb/tb_lecteur_historique_de.sv
module tb_lecteur_historique_de;

  localparam int N = 4;
  localparam int D = 8;
  localparam int SETTLE = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_l, b_p, b_s;
  logic [6:0] result;
  logic [6:0] hist_val;
  logic [3:0] hist_idx;
  logic [4:0] hist_count;
  logic       hist_valid;
  logic [3:0] uni, diz, ce;

  always #5 clk = ~clk;

  lecteur_historique_de #(
    .DEPTH          (D),
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (18)
  ) dut (
    .ClkIn    (clk),
    .RstIn    (rst),
    .BLancer  (b_l),
    .BPrec    (b_p),
    .BSuiv    (b_s),
    .Result   (result),
    .HistVal  (hist_val),
    .HistIdx  (hist_idx),
    .HistCount(hist_count),
    .HistValid(hist_valid),
    .Hist_Uni (uni),
    .Hist_Diz (diz),
    .Hist_Ce  (ce)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: newest roll at the front of the queue.
  int hist[$];
  int m_idx;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    hist.delete();
    m_idx = 0;
  endtask

  task automatic model_apply(input bit l, input bit p, input bit s, input int val);
    if (l) begin
      hist.push_front(val);
      if (hist.size() > D) void'(hist.pop_back());
      m_idx = 0;
    end else if (p && !s) begin
      if (m_idx < hist.size() - 1) m_idx++;
    end else if (s && !p) begin
      if (m_idx > 0) m_idx--;
    end
  endtask

  task automatic check_all(input string tag);
    int v;
    v = (hist.size() != 0) ? hist[m_idx] : 0;
    check_eq({tag, ".val"},   int'(hist_val),   v);
    check_eq({tag, ".idx"},   int'(hist_idx),   m_idx);
    check_eq({tag, ".count"}, int'(hist_count), hist.size());
    check_eq({tag, ".valid"}, int'(hist_valid), (hist.size() != 0) ? 1 : 0);
    check_eq({tag, ".ce"},    int'(ce),         v / 100);
    check_eq({tag, ".diz"},   int'(diz),        (v % 100) / 10);
    check_eq({tag, ".uni"},   int'(uni),        v % 10);
    $display("txn %-10s val=%0d idx=%0d count=%0d bcd=%0d%0d%0d", tag,
             hist_val, hist_idx, hist_count, ce, diz, uni);
  endtask

  // Hold the chosen buttons for 'hold' cycles, release, let everything settle.
  // Only a press stable for at least N synchronized cycles is a real press.
  task automatic press(input bit l, input bit p, input bit s, input int hold, input int val);
    @(negedge clk);
    result = 7'(val);
    b_l = l; b_p = p; b_s = s;
    tick(hold);
    b_l = 1'b0; b_p = 1'b0; b_s = 1'b0;
    tick(SETTLE);
    if (hold >= N) model_apply(l, p, s, val);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    model_reset();
    tick(2);
  endtask

  initial begin
    int bcd_vals[6];
    rst = 1'b1; b_l = 0; b_p = 0; b_s = 0; result = '0;
    model_reset();
    tick(6);
    rst = 1'b0;
    tick(SETTLE);
    check_all("reset");

    // Three launches, then browse back and forth.
    press(1, 0, 0, 6, 6);
    press(1, 0, 0, 6, 12);
    press(1, 0, 0, 6, 100);
    check_all("l3");
    for (int i = 0; i < 3; i++) begin press(0, 1, 0, 6, 100); check_all("prec"); end
    for (int i = 0; i < 3; i++) begin press(0, 0, 1, 6, 100); check_all("suiv"); end
    press(0, 1, 0, 6, 0);
    press(0, 1, 0, 6, 0);
    check_all("at_idx2");
    press(1, 0, 0, 6, 20);
    check_all("l20");

    // Saturation: ten launches, then walk to the oldest and past it.
    for (int i = 1; i <= 10; i++) press(1, 0, 0, 6, i);
    check_all("sat");
    for (int i = 0; i < 7; i++) press(0, 1, 0, 6, 0);
    check_all("oldest");
    press(0, 1, 0, 6, 0);
    check_all("oldhold");

    // Glitches: 3 cycles high, 3 low, 2 high -> nothing accepted.
    @(negedge clk);
    result = 7'd55;
    b_l = 1'b1; tick(3); b_l = 1'b0; tick(3); b_l = 1'b1; tick(2); b_l = 1'b0;
    tick(SETTLE);
    check_all("glitch");
    press(1, 0, 0, 6, 33);
    check_all("clean6");
    press(1, 0, 0, 100, 44);
    check_all("hold100");
    press(1, 0, 0, N, 45);
    check_all("exactN");
    press(1, 0, 0, N - 1, 46);
    check_all("shortN");

    // Launch and BPrec together: launch wins; BPrec and BSuiv together: neither.
    press(0, 1, 0, 6, 0);
    press(1, 1, 0, 6, 77);
    check_all("l_and_p");
    press(0, 1, 0, 6, 0);
    press(0, 1, 1, 6, 0);
    check_all("p_and_s");

    // BCD boundary values.
    bcd_vals = '{127, 99, 100, 9, 10, 0};
    foreach (bcd_vals[i]) begin
      press(1, 0, 0, 6, bcd_vals[i]);
      check_all("bcd");
    end

    // Randomized mix, including sub-threshold presses.
    for (int it = 0; it < 80; it++) begin
      int r, hold, val;
      r    = $urandom_range(0, 9);
      hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, N - 1) : $urandom_range(N, N + 4);
      val  = $urandom_range(0, 127);
      case (r)
        0, 1, 2, 3: press(1, 0, 0, hold, val);
        4, 5:       press(0, 1, 0, hold, val);
        6, 7:       press(0, 0, 1, hold, val);
        8:          press(0, 1, 1, hold, val);
        default:    press(1, 1, 0, hold, val);
      endcase
      check_all("rand");
    end

    // Launch held through reset must not write after reset.
    @(negedge clk);
    result = 7'd90;
    b_l = 1'b1; tick(2);
    rst = 1'b1; tick(3); rst = 1'b0;
    model_reset();
    tick(10);
    check_all("heldrst");
    b_l = 1'b0;
    tick(SETTLE);
    check_all("heldrel");
    press(1, 0, 0, 6, 91);
    press(1, 0, 0, 6, 92);
    check_all("postrst");

    // Reset in the middle of a BPrec debounce.
    @(negedge clk);
    b_p = 1'b1; tick(2);
    rst = 1'b1; tick(3); rst = 1'b0;
    model_reset();
    tick(10);
    b_p = 1'b0;
    tick(SETTLE);
    check_all("rstprec");
    press(1, 0, 0, 6, 5);
    check_all("after");

    do_reset();
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
